// File: rtl/pwm_multi_deadtime_if.sv
// Control and gate-drive signal bundle for pwm_multi_deadtime.
// The master is the control loop; the slave is the PWM block.
interface pwm_multi_deadtime_if #(
  parameter int unsigned CH   = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned DT_W = 6
);
  logic            en;
  logic            load;
  logic [W-1:0]    period;
  logic            center;
  logic [DT_W-1:0] dead;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   pwm_h;
  logic [CH-1:0]   pwm_l;
  logic            co;
  logic            pend;

  modport master (
    output en, load, period, center, dead, duty,
    input  pwm_h, pwm_l, co, pend
  );

  modport slave (
    input  en, load, period, center, dead, duty,
    output pwm_h, pwm_l, co, pend
  );
endinterface

// File: rtl/pwm_multi_deadtime.sv
// Multi-channel PWM: shared edge/center-aligned counter, shadow-buffered settings
// applied at period boundaries, complementary outputs with dead-time insertion.
module pwm_multi_deadtime #(
  parameter int unsigned CH   = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned DT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  pwm_multi_deadtime_if.slave bus
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [W-1:0]    CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0] DT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0] DT_MAX  = '1;

  logic            run;
  logic [W-1:0]    cnt, cnt_nxt;
  dir_t            dir, dir_nxt;

  logic [W-1:0]    sh_period, act_period;
  logic            sh_center, act_center;
  logic [DT_W-1:0] sh_dead, act_dead;
  logic [CH*W-1:0] sh_duty, act_duty;
  logic            pend;

  logic [CH-1:0]   raw_q, raw_nxt;
  logic [DT_W-1:0] dtcnt [CH];

  logic            co;
  logic            apply;

  // State register: counter, direction, settings, compare and dead-time state
  always_ff @(posedge clk) begin
    if (rst) begin
      run        <= 1'b0;
      cnt        <= '0;
      dir        <= DIR_UP;
      sh_period  <= '1;
      act_period <= '1;
      sh_center  <= 1'b0;
      act_center <= 1'b0;
      sh_dead    <= '0;
      act_dead   <= '0;
      sh_duty    <= '0;
      act_duty   <= '0;
      pend       <= 1'b0;
      raw_q      <= '0;
      for (int unsigned i = 0; i < CH; i++) dtcnt[i] <= '0;
    end else begin
      run   <= bus.en;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
      raw_q <= raw_nxt;
      for (int unsigned i = 0; i < CH; i++) begin
        if (!run || (raw_nxt[i] != raw_q[i])) dtcnt[i] <= '0;
        else if (dtcnt[i] != DT_MAX)          dtcnt[i] <= dtcnt[i] + DT_ONE;
      end
      if (!run) begin
        // Idle: settings take effect immediately, nothing is left pending
        if (bus.load) begin
          sh_period  <= bus.period;
          sh_center  <= bus.center;
          sh_dead    <= bus.dead;
          sh_duty    <= bus.duty;
          act_period <= bus.period;
          act_center <= bus.center;
          act_dead   <= bus.dead;
          act_duty   <= bus.duty;
          pend       <= 1'b0;
        end
      end else begin
        if (apply) begin
          act_period <= sh_period;
          act_center <= sh_center;
          act_dead   <= sh_dead;
          act_duty   <= sh_duty;
          pend       <= 1'b0;
        end
        // A load coincident with the boundary refills the shadow after the transfer
        if (bus.load) begin
          sh_period <= bus.period;
          sh_center <= bus.center;
          sh_dead   <= bus.dead;
          sh_duty   <= bus.duty;
          pend      <= 1'b1;
        end
      end
    end
  end

  // Next-state: counter and direction; dir marks the direction of the next step
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!run || apply || (act_period == '0)) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!act_center) begin
      dir_nxt = DIR_UP;
      cnt_nxt = (cnt == act_period) ? '0 : cnt + CNT_ONE;
    end else if (dir == DIR_UP) begin
      cnt_nxt = cnt + CNT_ONE;
      if ((cnt + CNT_ONE) == act_period) dir_nxt = DIR_DOWN;
    end else begin
      cnt_nxt = cnt - CNT_ONE;
      if (cnt == CNT_ONE) dir_nxt = DIR_UP;
    end
  end

  always_comb begin
    raw_nxt = '0;
    for (int unsigned i = 0; i < CH; i++)
      raw_nxt[i] = run & (act_duty[i*W +: W] > cnt);
  end

  // Outputs: boundary pulse and dead-time gated complementary pair
  always_comb begin
    co = 1'b0;
    if (run) begin
      if (act_period == '0) co = 1'b1;
      else if (act_center)  co = (dir == DIR_DOWN) && (cnt == CNT_ONE);
      else                  co = (cnt == act_period);
    end
    apply     = co & pend;
    bus.co    = co;
    bus.pend  = pend;
    bus.pwm_h = '0;
    bus.pwm_l = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      bus.pwm_h[i] = run &  raw_q[i] & (dtcnt[i] >= act_dead);
      bus.pwm_l[i] = run & ~raw_q[i] & (dtcnt[i] >= act_dead);
    end
  end

endmodule

// File: tb/tb_pwm_multi_deadtime.sv
// Directed bench for pwm_multi_deadtime: a phase-based reference predicts every cycle's
// outputs into a scoreboard queue; window counters check duty/dead-time totals.
module tb_pwm_multi_deadtime;
  localparam int CH = 4, W = 8, DT_W = 6;
  localparam int DT_SAT = (1 << DT_W) - 1;

  typedef struct {
    logic [2*CH+1:0] v;
    string           tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multi_deadtime_if #(.CH(CH), .W(W), .DT_W(DT_W)) bus ();
  pwm_multi_deadtime #(.CH(CH), .W(W), .DT_W(DT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  exp_t  sb[$];
  string cur_tag = "reset";

  // Reference state: position in the current period segment and applied settings
  int m_run, m_ph, m_pend;
  int a_P, a_c, a_D, s_P, s_c, s_D;
  int a_duty[CH], s_duty[CH], m_raw[CH], m_dt[CH];

  // Window counters maintained by the monitor
  int hcnt[CH], lcnt[CH], cocnt, ovl, anycnt;

  function automatic int cnt_of(int ph);
    int m;
    if (a_P == 0) return 0;
    if (a_c == 0) return ph % (a_P + 1);
    m = ph % (2 * a_P);
    return (m <= a_P) ? m : 2 * a_P - m;
  endfunction

  function automatic bit m_co();
    if (m_run == 0) return 1'b0;
    if (a_P == 0) return 1'b1;
    if (a_c != 0) return (m_ph % (2 * a_P)) == (2 * a_P - 1);
    return (m_ph % (a_P + 1)) == a_P;
  endfunction

  task automatic model_reset();
    m_run = 0; m_ph = 0; m_pend = 0;
    a_P = (1 << W) - 1; a_c = 0; a_D = 0;
    s_P = a_P; s_c = 0; s_D = 0;
    for (int i = 0; i < CH; i++) begin
      a_duty[i] = 0; s_duty[i] = 0; m_raw[i] = 0; m_dt[i] = 0;
    end
  endtask

  task automatic push_exp();
    logic [CH-1:0] h, l;
    exp_t e;
    for (int i = 0; i < CH; i++) begin
      h[i] = (m_run != 0) && (m_raw[i] != 0) && (m_dt[i] >= a_D);
      l[i] = (m_run != 0) && (m_raw[i] == 0) && (m_dt[i] >= a_D);
    end
    e.v   = {h, l, m_co(), m_pend != 0};
    e.tag = cur_tag;
    sb.push_back(e);
  endtask

  task automatic model_step();
    bit co;
    int c, nr;
    if (rst) begin
      model_reset();
      return;
    end
    co = m_co();
    c  = cnt_of(m_ph);
    for (int i = 0; i < CH; i++) begin
      nr = (m_run != 0 && a_duty[i] > c) ? 1 : 0;
      m_dt[i]  = (m_run == 0 || nr != m_raw[i]) ? 0 : ((m_dt[i] < DT_SAT) ? m_dt[i] + 1 : DT_SAT);
      m_raw[i] = nr;
    end
    if (m_run == 0) begin
      m_ph = 0;
      if (bus.load) begin
        s_P = int'(bus.period); s_c = int'(bus.center); s_D = int'(bus.dead);
        a_P = s_P; a_c = s_c; a_D = s_D;
        for (int i = 0; i < CH; i++) begin
          s_duty[i] = int'(bus.duty[i*W +: W]);
          a_duty[i] = s_duty[i];
        end
        m_pend = 0;
      end
    end else begin
      if (co && m_pend != 0) begin
        m_ph = 0;
        a_P = s_P; a_c = s_c; a_D = s_D;
        for (int i = 0; i < CH; i++) a_duty[i] = s_duty[i];
        m_pend = 0;
      end else begin
        m_ph++;
      end
      if (bus.load) begin
        s_P = int'(bus.period); s_c = int'(bus.center); s_D = int'(bus.dead);
        for (int i = 0; i < CH; i++) s_duty[i] = int'(bus.duty[i*W +: W]);
        m_pend = 1;
      end
    end
    m_run = bus.en ? 1 : 0;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      push_exp();
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < CH; i++) begin hcnt[i] = 0; lcnt[i] = 0; end
    cocnt = 0; ovl = 0; anycnt = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic load_cfg(input int p, input int c, input int d, input logic [CH*W-1:0] dv);
    bus.period = p[W-1:0];
    bus.center = c[0];
    bus.dead   = d[DT_W-1:0];
    bus.duty   = dv;
    bus.load   = 1'b1;
    cyc(1);
    bus.load   = 1'b0;
  endtask

  logic [2*CH+1:0] mon_obs;
  exp_t            mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_obs = {bus.pwm_h, bus.pwm_l, bus.co, bus.pend};
      checks++;
      assert (mon_obs === mon_e.v)
      else begin
        errors++;
        $error("FAIL %s: observed h/l/co/pend %b expected %b", mon_e.tag, mon_obs, mon_e.v);
      end
      for (int i = 0; i < CH; i++) begin
        hcnt[i] += int'(bus.pwm_h[i]);
        lcnt[i] += int'(bus.pwm_l[i]);
      end
      cocnt  += int'(bus.co);
      ovl    += int'(|(bus.pwm_h & bus.pwm_l));
      anycnt += int'(|{bus.pwm_h, bus.pwm_l, bus.co});
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    bus.en = 1'b0; bus.load = 1'b0; bus.period = '0; bus.center = 1'b0;
    bus.dead = '0; bus.duty = '0;
    model_reset();
    clr();
    @(posedge clk);
    model_step();
    #1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Edge mode, P=9, D=0, loaded while idle together with en
    cur_tag = "edge_d0";
    bus.en = 1'b1;
    load_cfg(9, 0, 0, {8'd0, 8'd10, 8'd5, 8'd3});
    cyc(12);
    clr(); cyc(10);
    chk("edge_d0_h0", hcnt[0], 3);
    chk("edge_d0_l0", lcnt[0], 7);
    chk("edge_d0_co", cocnt, 1);
    chk("edge_d0_h1", hcnt[1], 5);

    // Dead time 2 applied at the next boundary
    cur_tag = "edge_d2";
    load_cfg(9, 0, 2, {8'd0, 8'd10, 8'd5, 8'd3});
    cyc(24);
    clr(); cyc(10);
    chk("edge_d2_h0", hcnt[0], 1);
    chk("edge_d2_l0", lcnt[0], 5);
    chk("edge_d2_ovl", ovl, 0);

    cur_tag = "edge_d2_short";
    load_cfg(9, 0, 2, {8'd0, 8'd10, 8'd5, 8'd2});
    cyc(24);
    clr(); cyc(10);
    chk("short_h0", hcnt[0], 0);
    chk("short_ovl", ovl, 0);

    // Center-aligned, P=4
    cur_tag = "center";
    load_cfg(4, 1, 0, {8'd0, 8'd5, 8'd2, 8'd1});
    cyc(24);
    clr(); cyc(8);
    chk("center_co", cocnt, 1);
    chk("center_h1", hcnt[1], 3);
    chk("center_h2", hcnt[2], 8);
    chk("center_h0", hcnt[0], 1);

    // Shadow: mid-period load, then a load coincident with the boundary
    cur_tag = "shadow";
    load_cfg(9, 0, 0, {8'd0, 8'd10, 8'd5, 8'd3});
    cyc(25);
    load_cfg(9, 0, 0, {8'd0, 8'd10, 8'd5, 8'd7});
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (m_co()) found = 1'b1;
      else cyc(1);
    end
    if (!found) begin
      errors++;
      $error("FAIL shadow_co_wait: observed no boundary expected one within 40 cycles");
    end
    cur_tag = "shadow_coincident";
    load_cfg(9, 0, 0, {8'd0, 8'd10, 8'd5, 8'd5});
    cyc(25);

    // Duty extremes: 0 and P+1
    cur_tag = "extremes";
    load_cfg(9, 0, 0, {8'd0, 8'd10, 8'd10, 8'd0});
    cyc(25);
    clr(); cyc(10);
    chk("ext_h0", hcnt[0], 0);
    chk("ext_l0", lcnt[0], 10);
    chk("ext_h1", hcnt[1], 10);

    // Drop enable
    cur_tag = "disable";
    bus.en = 1'b0;
    cyc(2);
    clr(); cyc(6);
    chk("dis_any", anycnt, 0);

    // Reset with a pending load: the old shadow must never be applied
    cur_tag = "rst_pend";
    bus.en = 1'b1;
    cyc(5);
    load_cfg(9, 0, 0, {8'd0, 8'd10, 8'd10, 8'd4});
    cyc(2);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(270);
    clr(); cyc(20);
    chk("rst_h0", hcnt[0], 0);
    chk("rst_l0", lcnt[0], 20);

    bus.en = 1'b0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
